fc_align_ctrl: RTL
==================

Name: fc_align_ctrl

Overview:
Automatic alignment controller for the fast-command receive path. It sweeps the four clock/command delay settings of the phase adjuster and watches the decoded fast-command words from the word-aligning decoder. It locks on the first setting that yields a run of clean IDLE words, and re-runs the sweep when a locked link degrades. It sits beside the manual-alignment top and drives its clkDelayEn/fcDelayEn inputs, with a manual override.

Parameters:
IDLE_CODE, 10'h001, decoded fcd value for the IDLE command
SETTLE_CYCLES, 16, clk320 cycles to wait after any delay change before evaluating words (≥1)
LOCK_COUNT, 32, consecutive IDLE words required to lock (≥1)
WINDOW, 256, maximum words evaluated per delay setting (> LOCK_COUNT)
ERR_LIMIT, 4, consecutive invalid words in LOCKED that drop lock (≥1)

Ports:
clk320  input  1  320 MHz clock; the single clock domain
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; begins a sweep from IDLE or FAIL
man_en  input  1  manual override enable
man_clkDelayEn  input  1  clkDelayEn value used while man_en=1
man_fcDelayEn  input  1  fcDelayEn value used while man_en=1
fcd  input  10  decoded fast-command word from the decoder
fcd_valid  input  1  fcd is a new word this cycle
clkDelayEn  output  1  clock delay enable to the phase adjuster
fcDelayEn  output  1  command delay enable to the phase adjuster
locked  output  1  alignment locked
align_fail  output  1  sweep exhausted without lock
lock_phase  output  2  phase index in use ({fcDelayEn, clkDelayEn})
relock_cnt  output  8  number of lock losses, saturating
state_dbg  output  3  current state encoding

Behaviour:
- All outputs are registered. Reset, or any cycle with rst=1, forces the following on the next edge: state IDLE, phase 0, all outputs 0, relock_cnt 0, all counters 0. rst has priority over all inputs.
- Phase order is 0→1→2→3. clkDelayEn=phase[0]; fcDelayEn=phase[1]. lock_phase=phase.
- man_en=1 (priority below rst):
  - State goes to IDLE next cycle.
  - clkDelayEn/fcDelayEn follow the man_* inputs, registered with 1-cycle latency.
  - locked=0, align_fail=0. start is ignored.
  - relock_cnt is held.
- States (state_dbg): IDLE=0, SETTLE=1, SEARCH=2, LOCKED=3, FAIL=4.
- IDLE:
  - Delay outputs hold their last value.
  - start=1 → SETTLE with phase=0, settle counter cleared.
- SETTLE:
  - Counts clk320 cycles. fcd_valid is ignored.
  - After SETTLE_CYCLES cycles → SEARCH, with word_cnt and match_cnt cleared.
- SEARCH, on each fcd_valid:
  - word_cnt+1.
  - fcd==IDLE_CODE → match_cnt+1; otherwise match_cnt=0.
  - If this word brings match_cnt to LOCK_COUNT → LOCKED, and locked=1 on the same edge.
  - Else if this word brings word_cnt to WINDOW: phase<3 → phase+1 and SETTLE; phase==3 → FAIL.
  - Lock takes priority when both conditions occur on the same word.
- LOCKED:
  - A word is invalid when fcd_valid=1 and fcd is zero or not one-hot. Invalid → err_cnt+1. Any valid one-hot word → err_cnt=0.
  - err_cnt reaching ERR_LIMIT → locked=0, relock_cnt+1 (saturates at 255), phase=0, SETTLE.
  - start is ignored.
- FAIL:
  - align_fail=1 and phase=3 are held.
  - start → align_fail=0, phase=0, SETTLE.
- start arriving in SETTLE or SEARCH is ignored; a sweep in progress is never restarted by start.
- fcd_valid arriving on the same cycle as a state transition is evaluated only by the state that was current on that cycle.

Test Plan:
- Reset, then start with fcd=IDLE_CODE every 8 cycles → SETTLE lasts 16 cycles. locked=1 on the edge of the 32nd valid word; lock_phase=0, clkDelayEn=0, fcDelayEn=0.
- Stimulus: fcd=10'h000 for phases 0–1, IDLE_CODE from phase 2 onward → 256 words each on phases 0 and 1, then lock with lock_phase=2, fcDelayEn=1, clkDelayEn=0.
- Stimulus: no IDLE words on any phase → after 4×256 words, align_fail=1, state_dbg=4, lock_phase=3. A following start → align_fail=0, phase=0, state_dbg=1.
- While LOCKED, inject 3 invalid words, one valid command, then 4 invalid words → stays locked after the first 3. After the 4th consecutive invalid word: locked=0, relock_cnt=1, state_dbg=1, phase=0.
- Stimulus: IDLE_CODE for 31 words, one mismatch, then 32 IDLEs → no lock at the 32nd word; lock occurs at word 64.
- Assert rst in mid-SEARCH at phase 2 → next cycle all outputs 0 and state IDLE. Assert man_en=1 with man_clkDelayEn=1 → clkDelayEn=1 one cycle later, locked=0, start ignored.

Source files
------------

// File: rtl/fc_word_if.sv
// Decoded fast-command word stream from the word-aligning decoder to the alignment controller.
// Handshake: fcd is a new word on each cycle fcd_valid=1. There is no ready; the consumer takes every word.
interface fc_word_if;
    logic [9:0] fcd;
    logic       fcd_valid;

    modport master (output fcd, output fcd_valid);
    modport slave  (input  fcd, input  fcd_valid);
endinterface

// File: rtl/fc_align_ctrl.sv
// Automatic alignment controller: sweeps the four clock/command delay phases, locks on a run of
// clean IDLE words, and re-sweeps when a locked link sees a burst of invalid words.
module fc_align_ctrl #(
    parameter logic [9:0] IDLE_CODE     = 10'h001,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         LOCK_COUNT    = 32,
    parameter int         WINDOW        = 256,
    parameter int         ERR_LIMIT     = 4
) (
    input  logic       clk320,
    input  logic       rst,
    input  logic       start,
    input  logic       man_en,
    input  logic       man_clkDelayEn,
    input  logic       man_fcDelayEn,
    fc_word_if.slave   word,
    output logic       clkDelayEn,
    output logic       fcDelayEn,
    output logic       locked,
    output logic       align_fail,
    output logic [1:0] lock_phase,
    output logic [7:0] relock_cnt,
    output logic [2:0] state_dbg
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SEARCH = 3'd2,
        S_LOCKED = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic            clk_q, clk_d, fc_q, fc_d;
    logic            locked_q, locked_d, fail_q, fail_d;
    logic [7:0]      relock_q, relock_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [WW-1:0]   word_q, word_d, word_inc;
    logic [MW-1:0]   match_q, match_d, match_inc;
    logic [EW-1:0]   err_q, err_d, err_inc;
    logic [1:0]      phase_inc;
    logic            is_idle, one_hot;

    assign word_inc  = word_q + 1'b1;
    assign match_inc = match_q + 1'b1;
    assign err_inc   = err_q + 1'b1;
    assign phase_inc = phase_q + 2'd1;
    assign is_idle   = (word.fcd == IDLE_CODE);
    assign one_hot   = (word.fcd != 10'd0) && ((word.fcd & (word.fcd - 10'd1)) == 10'd0);

    always_ff @(posedge clk320) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= 2'd0;
            clk_q    <= 1'b0;
            fc_q     <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            relock_q <= 8'd0;
            settle_q <= '0;
            word_q   <= '0;
            match_q  <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            clk_q    <= clk_d;
            fc_q     <= fc_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
            relock_q <= relock_d;
            settle_q <= settle_d;
            word_q   <= word_d;
            match_q  <= match_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        clk_d    = clk_q;
        fc_d     = fc_q;
        locked_d = locked_q;
        fail_d   = fail_q;
        relock_d = relock_q;
        settle_d = settle_q;
        word_d   = word_q;
        match_d  = match_q;
        err_d    = err_q;
        if (man_en) begin
            state_d  = S_IDLE;
            clk_d    = man_clkDelayEn;
            fc_d     = man_fcDelayEn;
            locked_d = 1'b0;
            fail_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d  = S_SETTLE;
                    phase_d  = 2'd0;
                    clk_d    = 1'b0;
                    fc_d     = 1'b0;
                    settle_d = '0;
                end
                S_SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_d = S_SEARCH;
                        word_d  = '0;
                        match_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                S_SEARCH: if (word.fcd_valid) begin
                    word_d  = word_inc;
                    match_d = is_idle ? match_inc : '0;
                    // Lock wins over window exhaustion on the same word.
                    if (is_idle && (match_inc == MW'(LOCK_COUNT))) begin
                        state_d  = S_LOCKED;
                        locked_d = 1'b1;
                        err_d    = '0;
                    end else if (word_inc == WW'(WINDOW)) begin
                        if (phase_q != 2'd3) begin
                            state_d  = S_SETTLE;
                            phase_d  = phase_inc;
                            clk_d    = phase_inc[0];
                            fc_d     = phase_inc[1];
                            settle_d = '0;
                        end else begin
                            state_d = S_FAIL;
                            fail_d  = 1'b1;
                        end
                    end
                end
                S_LOCKED: if (word.fcd_valid) begin
                    if (!one_hot) begin
                        err_d = err_inc;
                        if (err_inc == EW'(ERR_LIMIT)) begin
                            state_d  = S_SETTLE;
                            locked_d = 1'b0;
                            relock_d = (relock_q == 8'hff) ? relock_q : relock_q + 8'd1;
                            phase_d  = 2'd0;
                            clk_d    = 1'b0;
                            fc_d     = 1'b0;
                            settle_d = '0;
                        end
                    end else begin
                        err_d = '0;
                    end
                end
                S_FAIL: if (start) begin
                    state_d  = S_SETTLE;
                    fail_d   = 1'b0;
                    phase_d  = 2'd0;
                    clk_d    = 1'b0;
                    fc_d     = 1'b0;
                    settle_d = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign clkDelayEn = clk_q;
    assign fcDelayEn  = fc_q;
    assign locked     = locked_q;
    assign align_fail = fail_q;
    assign lock_phase = phase_q;
    assign relock_cnt = relock_q;
    assign state_dbg  = state_q;
endmodule
